// File: rtl/ps2_mouse_read_funcmod_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_mouse_read_funcmod_if
//  Description : Bundles the PS/2 line inputs, the receive enable and the
//                decoded mouse packet outputs of ps2_mouse_read_funcmod.
//                slave  - receiver side (ps2_mouse_read_funcmod)
//                master - environment side (PS/2 device + consumer)
//  Ports       : PS2_CLK, PS2_DAT  PS/2 lines (receiver only listens)
//                iEn               receive enable (level)
//                oTrig / oErr      one-cycle packet / discard pulses
//                oBtn, oX, oY      {M,R,L} buttons, signed 9-bit deltas
//  Revision    : 1.0 - initial release
// ============================================================================
interface ps2_mouse_read_funcmod_if;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic       iEn;
    logic       oTrig;
    logic [2:0] oBtn;
    logic [8:0] oX;
    logic [8:0] oY;
    logic       oErr;

    modport slave (
        input  PS2_CLK, PS2_DAT, iEn,
        output oTrig, oBtn, oX, oY, oErr
    );

    modport master (
        output PS2_CLK, PS2_DAT, iEn,
        input  oTrig, oBtn, oX, oY, oErr
    );
endinterface
`default_nettype wire

// File: rtl/ps2_mouse_read_funcmod.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_mouse_read_funcmod
//  Description : Listen-only PS/2 mouse packet receiver. Deserialises
//                11-bit device-to-host frames, checks start/parity/stop and
//                the byte-0 sync bit, and publishes buttons plus signed
//                9-bit X/Y deltas with a one-cycle oTrig. Any discarded
//                packet (parity, stop, sync, inter-edge timeout) gives a
//                one-cycle oErr and a resync to byte 0.
//  Ports       : CLOCK  system clock
//                RESET  asynchronous active-high reset
//                bus    ps2_mouse_read_funcmod_if.slave
//                       (PS2_CLK, PS2_DAT, iEn in; oTrig, oBtn, oX, oY,
//                        oErr out)
//  Parameters  : TIMEOUT  max CLOCK cycles between PS2_CLK falling edges
//                         inside a packet before it is aborted
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_mouse_read_funcmod #(
    parameter logic [16:0] TIMEOUT = 17'd100000
) (
    input  wire logic               CLOCK,
    input  wire logic               RESET,
    ps2_mouse_read_funcmod_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [16:0] c_TMO_LAST = TIMEOUT - 17'd1;

    // Line synchronisers
    logic        r_clkF1, r_clkF2;
    logic        r_datF1, r_datF2;

    state_t      r_state;
    logic [2:0]  r_bitCnt;
    logic [1:0]  r_idx;
    logic [7:0]  r_shift;
    logic        r_parOk;
    logic [16:0] r_tmo;

    // Fields kept from bytes 0 and 1 until byte 2 completes the packet
    logic [2:0]  r_btn;
    logic        r_xSign;
    logic        r_ySign;
    logic [7:0]  r_byte1;

    // Registered outputs
    logic        r_trig;
    logic        r_err;
    logic [2:0]  r_oBtn;
    logic [8:0]  r_oX;
    logic [8:0]  r_oY;

    logic        w_fall;
    logic        w_dat;
    logic        w_inFrame;
    logic        w_tmoHit;

    assign w_fall = r_clkF2 & ~r_clkF1;
    assign w_dat  = r_datF2;

    // Timeout only matters once a packet is under way (byte 0 started or
    // later bytes awaited); the start search for byte 0 may wait forever.
    assign w_inFrame = (r_state == S_DATA) || (r_state == S_PARITY) ||
                       (r_state == S_STOP) ||
                       ((r_state == S_START) && (r_idx != 2'd0));
    assign w_tmoHit  = w_inFrame && !w_fall && (r_tmo == c_TMO_LAST);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_clkF1  <= 1'b1;
            r_clkF2  <= 1'b1;
            r_datF1  <= 1'b1;
            r_datF2  <= 1'b1;
            r_state  <= S_IDLE;
            r_bitCnt <= 3'd0;
            r_idx    <= 2'd0;
            r_shift  <= 8'd0;
            r_parOk  <= 1'b0;
            r_tmo    <= 17'd0;
            r_btn    <= 3'd0;
            r_xSign  <= 1'b0;
            r_ySign  <= 1'b0;
            r_byte1  <= 8'd0;
            r_trig   <= 1'b0;
            r_err    <= 1'b0;
            r_oBtn   <= 3'd0;
            r_oX     <= 9'd0;
            r_oY     <= 9'd0;
        end else begin
            r_clkF1 <= bus.PS2_CLK;
            r_clkF2 <= r_clkF1;
            r_datF1 <= bus.PS2_DAT;
            r_datF2 <= r_datF1;

            r_trig  <= 1'b0;
            r_err   <= 1'b0;

            // Inter-edge timer; held at its last value rather than wrapping
            if (w_fall || (r_state == S_IDLE) ||
                ((r_state == S_START) && (r_idx == 2'd0)))
                r_tmo <= 17'd0;
            else if (r_tmo != c_TMO_LAST)
                r_tmo <= r_tmo + 17'd1;

            if (!bus.iEn) begin
                // Disable silently drops any partial packet
                r_state <= S_IDLE;
                r_idx   <= 2'd0;
            end else if (w_tmoHit) begin
                r_state <= S_ERR;
                r_err   <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_START;
                    end
                    S_START: begin
                        if (w_fall && !w_dat) begin
                            r_state  <= S_DATA;
                            r_bitCnt <= 3'd0;
                        end
                    end
                    S_DATA: begin
                        if (w_fall) begin
                            r_shift  <= {w_dat, r_shift[7:1]};
                            r_bitCnt <= r_bitCnt + 3'd1;
                            if (r_bitCnt == 3'd7)
                                r_state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        if (w_fall) begin
                            r_parOk <= ^{r_shift, w_dat};
                            r_state <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        if (w_fall) begin
                            if (!w_dat || !r_parOk) begin
                                r_state <= S_ERR;
                                r_err   <= 1'b1;
                            end else if ((r_idx == 2'd0) && !r_shift[3]) begin
                                // Byte 0 always carries bit 3 set; anything
                                // else means we are misaligned in the stream
                                r_state <= S_ERR;
                                r_err   <= 1'b1;
                            end else if (r_idx == 2'd2) begin
                                r_state <= S_DONE;
                                r_trig  <= 1'b1;
                                r_oBtn  <= r_btn;
                                r_oX    <= {r_xSign, r_byte1};
                                r_oY    <= {r_ySign, r_shift};
                            end else begin
                                if (r_idx == 2'd0) begin
                                    r_btn   <= r_shift[2:0];
                                    r_xSign <= r_shift[4];
                                    r_ySign <= r_shift[5];
                                end else begin
                                    r_byte1 <= r_shift;
                                end
                                r_idx   <= r_idx + 2'd1;
                                r_state <= S_START;
                            end
                        end
                    end
                    S_DONE: begin
                        r_idx   <= 2'd0;
                        r_state <= S_START;
                    end
                    S_ERR: begin
                        r_idx   <= 2'd0;
                        r_state <= S_START;
                    end
                    default: begin
                        r_idx   <= 2'd0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.oTrig = r_trig;
    assign bus.oErr  = r_err;
    assign bus.oBtn  = r_oBtn;
    assign bus.oX    = r_oX;
    assign bus.oY    = r_oY;

endmodule
`default_nettype wire

// File: tb/tb_ps2_mouse_read_funcmod.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_ps2_mouse_read_funcmod
//  Description : Scoreboard bench for ps2_mouse_read_funcmod. A behavioural
//                PS/2 device sends frames (data changes while the clock is
//                high, host samples on the falling edge); the expected
//                oTrig/oErr events are queued as stimulus is issued and
//                compared as the receiver reports them. Timing is scaled
//                down: 20-cycle PS/2 half period, short TIMEOUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_mouse_read_funcmod;

    localparam int HALF = 20;
    localparam int TMO  = 300;

    typedef struct {
        bit         isErr;
        logic [2:0] btn;
        logic [8:0] x;
        logic [8:0] y;
    } exp_t;

    logic CLOCK;
    logic RESET;
    int   n_checks;
    int   n_fail;
    exp_t q[$];

    ps2_mouse_read_funcmod_if bus ();

    ps2_mouse_read_funcmod #(
        .TIMEOUT (17'(TMO))
    ) u_dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    initial CLOCK = 1'b0;
    always #10 CLOCK = ~CLOCK;

    task automatic check_value(input string tag, input logic [31:0] act,
                               input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic half_wait();
        repeat (HALF) @(negedge CLOCK);
    endtask

    // Sends the first nbits bits of an 11-bit frame, then idles the line
    task automatic send_frame(input logic [7:0] b, input bit badPar,
                              input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ badPar, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus.PS2_DAT = f[i];
            half_wait();
            bus.PS2_CLK = 1'b0;
            half_wait();
            bus.PS2_CLK = 1'b1;
        end
        bus.PS2_DAT = 1'b1;
        half_wait();
        half_wait();
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2);
        send_frame(b0, 1'b0, 11);
        send_frame(b1, 1'b0, 11);
        send_frame(b2, 1'b0, 11);
    endtask

    task automatic push_trig(input logic [2:0] btn, input logic [8:0] x,
                             input logic [8:0] y);
        exp_t e;
        e.isErr = 1'b0; e.btn = btn; e.x = x; e.y = y;
        q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.isErr = 1'b1; e.btn = 3'd0; e.x = 9'd0; e.y = 9'd0;
        q.push_back(e);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (q.size() > 0 && n < budget) begin
            @(negedge CLOCK);
            n++;
        end
        if (q.size() > 0) begin
            check_value(tag, q.size(), 0);
            q.delete();
        end
    endtask

    // Scoreboard consumer
    always @(posedge CLOCK) begin
        #1;
        if (bus.oTrig || bus.oErr) begin
            if (q.size() == 0) begin
                check_value("spurious_pulse", {30'd0, bus.oTrig, bus.oErr}, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check_value("pulse_kind", {30'd0, bus.oTrig, bus.oErr},
                            e.isErr ? 32'd1 : 32'd2);
                if (!e.isErr) begin
                    check_value("oBtn", {29'd0, bus.oBtn}, {29'd0, e.btn});
                    check_value("oX", {23'd0, bus.oX}, {23'd0, e.x});
                    check_value("oY", {23'd0, bus.oY}, {23'd0, e.y});
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        RESET       = 1'b1;
        bus.PS2_CLK = 1'b1;
        bus.PS2_DAT = 1'b1;
        bus.iEn     = 1'b0;
        repeat (5) @(negedge CLOCK);
        check_value("rst_oTrig", {31'd0, bus.oTrig}, 0);
        check_value("rst_oErr", {31'd0, bus.oErr}, 0);
        check_value("rst_oBtn", {29'd0, bus.oBtn}, 0);
        check_value("rst_oX", {23'd0, bus.oX}, 0);
        check_value("rst_oY", {23'd0, bus.oY}, 0);
        RESET = 1'b0;
        repeat (5) @(negedge CLOCK);

        // 1: receiver disabled, nothing must come out
        send_packet(8'h29, 8'h05, 8'hFB);
        repeat (50) @(negedge CLOCK);
        check_value("t1_oBtn", {29'd0, bus.oBtn}, 0);
        check_value("t1_oX", {23'd0, bus.oX}, 0);
        check_value("t1_oY", {23'd0, bus.oY}, 0);

        // 2: basic packet with negative Y
        bus.iEn = 1'b1;
        repeat (10) @(negedge CLOCK);
        push_trig(3'b001, 9'h005, 9'h1FB);
        send_packet(8'h29, 8'h05, 8'hFB);
        wait_drain("t2_drain", 200);

        // 3: parity error on byte 1, then a clean packet
        push_err();
        push_trig(3'b000, 9'h010, 9'h020);
        send_frame(8'h08, 1'b0, 11);
        send_frame(8'h55, 1'b1, 11);
        send_packet(8'h08, 8'h10, 8'h20);
        wait_drain("t3_drain", 200);

        // 4: byte 0 without sync bit, then resync
        push_err();
        push_trig(3'b010, 9'h0FF, 9'h001);
        send_frame(8'h01, 1'b0, 11);
        send_packet(8'h0A, 8'hFF, 8'h01);
        wait_drain("t4_drain", 200);

        // 5: stalled packet times out, then negative X
        push_err();
        send_frame(8'h18, 1'b0, 11);
        repeat (3 * TMO) @(negedge CLOCK);
        wait_drain("t5_tmo_drain", 10);
        push_trig(3'b000, 9'h1F6, 9'h000);
        send_packet(8'h18, 8'hF6, 8'h00);
        wait_drain("t5_drain", 200);

        // 6: reset in the middle of byte 1
        send_frame(8'h09, 1'b0, 11);
        send_frame(8'h33, 1'b0, 5);
        RESET = 1'b1;
        repeat (3) @(negedge CLOCK);
        check_value("t6_rst_oTrig", {31'd0, bus.oTrig}, 0);
        check_value("t6_rst_oErr", {31'd0, bus.oErr}, 0);
        check_value("t6_rst_oBtn", {29'd0, bus.oBtn}, 0);
        check_value("t6_rst_oX", {23'd0, bus.oX}, 0);
        check_value("t6_rst_oY", {23'd0, bus.oY}, 0);
        RESET = 1'b0;
        repeat (20) @(negedge CLOCK);
        push_trig(3'b001, 9'h003, 9'h004);
        send_packet(8'h09, 8'h03, 8'h04);
        wait_drain("t6_drain", 200);

        repeat (50) @(negedge CLOCK);
        check_value("final_pending", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
